// File: rtl/n64_line_phy.sv
// ----------------------------------------------------------------------------
// n64_line_phy
//
// Bit-level PHY for the N64 one-wire controller bus. It sits between the
// con_int register block and the bidirectional data_line pad. It sends a
// console command of up to 32 bits, MSB first, using pulse-width coding, and
// then the console stop bit. It then captures up to 32 controller response
// bits and checks the controller stop bit.
//
// Ports
//   PCLK      fabric clock
//   PRESERN   asynchronous active-low reset
//   start     one-cycle request, accepted only when idle
//   tx_data   command bits, right-justified
//   tx_bits   number of command bits to send (0..32, larger values saturate)
//   rx_bits   number of response bits to capture (0..32, larger saturate)
//   line_in   raw pad input (asynchronous to PCLK)
//   line_oe   1 = pull data_line low (pad is open-drain: data_line = oe ? 0 : Z)
//   busy      transaction in flight
//   done      one-cycle end-of-transaction pulse
//   rx_data   received bits, right-justified, first received bit is MSB
//   rx_count  response bits captured so far
//   rx_err    valid with done: timeout or missing controller stop bit
//
// State table
//   state       | meaning
//   ------------+------------------------------------------------------------
//   IDLE        | waiting for start
//   TX_LOW      | driving the low part of the current command bit
//   TX_HIGH     | releasing the line for the high part of the current bit
//   STOP_LOW    | console stop bit, low part
//   STOP_HIGH   | console stop bit, high part
//   RX_WAIT     | waiting for a controller falling edge (timeout armed)
//   RX_SAMPLE   | delaying from the detected edge to the bit sample point
//   RX_HIGH     | waiting for the controller to release the line
//   RX_STOP     | waiting for the controller stop bit (fall, then high)
//   DONE        | one-cycle completion, done pulse
// ----------------------------------------------------------------------------
module n64_line_phy #(
    parameter int CYC_PER_US = 100,
    parameter int TIMEOUT_US = 64
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        start,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_bits,
    input  logic [5:0]  rx_bits,
    input  logic        line_in,
    output logic        line_oe,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data,
    output logic [5:0]  rx_count,
    output logic        rx_err
);

    localparam int TO_CYC  = TIMEOUT_US * CYC_PER_US;
    localparam int MAX_CYC = (TO_CYC > 3 * CYC_PER_US) ? TO_CYC : 3 * CYC_PER_US;
    localparam int TW      = $clog2(MAX_CYC + 1);

    // Down-counter reload values: a phase of N cycles loads N-1 and ends
    // in the cycle where the counter reads zero.
    localparam logic [TW-1:0] T_1US = TW'(CYC_PER_US - 1);
    localparam logic [TW-1:0] T_2US = TW'(2 * CYC_PER_US - 1);
    localparam logic [TW-1:0] T_3US = TW'(3 * CYC_PER_US - 1);
    localparam logic [TW-1:0] T_TO  = TW'(TO_CYC - 1);
    localparam logic [TW-1:0] T_ONE = TW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_LOW,
        S_TX_HIGH,
        S_STOP_LOW,
        S_STOP_HIGH,
        S_RX_WAIT,
        S_RX_SAMPLE,
        S_RX_HIGH,
        S_RX_STOP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [4:0]     idx_q, idx_d;
    logic [31:0]    tx_data_q, tx_data_d;
    logic [5:0]     rx_bits_q, rx_bits_d;
    logic [31:0]    rx_data_q, rx_data_d;
    logic [5:0]     rx_count_q, rx_count_d;
    logic           rx_err_q, rx_err_d;
    logic           stop_fall_q, stop_fall_d;
    logic           line_oe_q, line_oe_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           prev_q, prev_d;

    logic           line_fall;
    logic [5:0]     tx_n;
    logic [5:0]     rx_n;
    logic [4:0]     tx_first;
    logic           cur_bit;
    logic           nxt_bit;

    assign line_fall = prev_q & ~sync2_q;

    assign tx_n = (tx_bits > 6'd32) ? 6'd32 : tx_bits;
    assign rx_n = (rx_bits > 6'd32) ? 6'd32 : rx_bits;
    // Five-bit wrap gives 31 for a 32-bit command, which is the wanted MSB.
    assign tx_first = tx_n[4:0] - 5'd1;

    assign cur_bit = tx_data_q[idx_q];
    assign nxt_bit = tx_data_q[idx_q - 5'd1];

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        rx_bits_d   = rx_bits_q;
        rx_data_d   = rx_data_q;
        rx_count_d  = rx_count_q;
        rx_err_d    = rx_err_q;
        stop_fall_d = stop_fall_q;

        sync1_d = line_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_data_d   = tx_data;
                    idx_d       = tx_first;
                    rx_bits_d   = rx_n;
                    rx_data_d   = '0;
                    rx_count_d  = '0;
                    rx_err_d    = 1'b0;
                    stop_fall_d = 1'b0;
                    if (tx_n != 6'd0) begin
                        state_d = S_TX_LOW;
                        tmr_d   = tx_data[tx_first] ? T_1US : T_3US;
                    end else if (rx_n != 6'd0) begin
                        state_d = S_RX_WAIT;
                        tmr_d   = T_TO;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_TX_LOW: begin
                if (tmr_q == '0) begin
                    state_d = S_TX_HIGH;
                    tmr_d   = cur_bit ? T_3US : T_1US;
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_TX_HIGH: begin
                if (tmr_q == '0) begin
                    if (idx_q != 5'd0) begin
                        idx_d   = idx_q - 5'd1;
                        state_d = S_TX_LOW;
                        tmr_d   = nxt_bit ? T_1US : T_3US;
                    end else begin
                        state_d = S_STOP_LOW;
                        tmr_d   = T_1US;
                    end
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_STOP_LOW: begin
                if (tmr_q == '0) begin
                    state_d = S_STOP_HIGH;
                    tmr_d   = T_2US;
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_STOP_HIGH: begin
                if (tmr_q == '0) begin
                    if (rx_bits_q == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RX_WAIT;
                        tmr_d   = T_TO;
                    end
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_RX_WAIT: begin
                if (line_fall) begin
                    state_d = S_RX_SAMPLE;
                    tmr_d   = T_2US;
                end else if (tmr_q == '0) begin
                    rx_err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_RX_SAMPLE: begin
                // Sample point sits between the 1 us and 3 us low widths.
                if (tmr_q == '0) begin
                    rx_data_d  = {rx_data_q[30:0], sync2_q};
                    rx_count_d = rx_count_q + 6'd1;
                    state_d    = S_RX_HIGH;
                    tmr_d      = T_TO;
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_RX_HIGH: begin
                if (sync2_q) begin
                    tmr_d = T_TO;
                    if (rx_count_q < rx_bits_q) begin
                        state_d = S_RX_WAIT;
                    end else begin
                        state_d     = S_RX_STOP;
                        stop_fall_d = 1'b0;
                    end
                end else if (tmr_q == '0) begin
                    rx_err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmr_d = tmr_q - T_ONE;
                end
            end

            S_RX_STOP: begin
                // One timeout window covers both the fall and the release.
                if (stop_fall_q && sync2_q) begin
                    state_d = S_DONE;
                end else if (tmr_q == '0) begin
                    rx_err_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmr_d = tmr_q - T_ONE;
                    if (line_fall) begin
                        stop_fall_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up exactly with the state they belong to.
        line_oe_d = (state_d == S_TX_LOW) || (state_d == S_STOP_LOW);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            rx_bits_q   <= '0;
            rx_data_q   <= '0;
            rx_count_q  <= '0;
            rx_err_q    <= 1'b0;
            stop_fall_q <= 1'b0;
            line_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            rx_bits_q   <= rx_bits_d;
            rx_data_q   <= rx_data_d;
            rx_count_q  <= rx_count_d;
            rx_err_q    <= rx_err_d;
            stop_fall_q <= stop_fall_d;
            line_oe_q   <= line_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
        end
    end

    assign line_oe  = line_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign rx_count = rx_count_q;
    assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_n64_line_phy.sv
// ----------------------------------------------------------------------------
// tb_n64_line_phy
//
// Drives n64_line_phy with CYC_PER_US=4, TIMEOUT_US=16. A behavioural
// controller model answers on the open-drain line; the expected line_oe
// waveform and receive results are built from the pulse-width rules.
// ----------------------------------------------------------------------------
module tb_n64_line_phy;

    localparam int C  = 4;
    localparam int TO = 16 * C;

    logic        PCLK    = 1'b0;
    logic        PRESERN = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_bits = '0;
    logic [5:0]  rx_bits = '0;
    logic        line_in;
    logic        line_oe;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;
    logic [5:0]  rx_count;
    logic        rx_err;
    logic        ctrl_low = 1'b0;

    int total = 0;
    int bad   = 0;

    // Open-drain wired-AND of console and controller.
    assign line_in = !(line_oe || ctrl_low);

    always #5 PCLK = ~PCLK;

    n64_line_phy #(
        .CYC_PER_US (C),
        .TIMEOUT_US (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESERN  (PRESERN),
        .start    (start),
        .tx_data  (tx_data),
        .tx_bits  (tx_bits),
        .rx_bits  (rx_bits),
        .line_in  (line_in),
        .line_oe  (line_oe),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .rx_count (rx_count),
        .rx_err   (rx_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One transaction. Cycle c=0 is the first cycle after start is sampled.
    task automatic run_txn(input logic [31:0] td, input int tb_bits, input int rb_bits,
                           input int nresp, input logic [31:0] resp, input bit stop,
                           input int gap, input int mid);
        int          tx_n, rx_n, txc, limit, done_c, done_cnt, oe_bad, busy_bad;
        bit          eo[$];
        bit          sched[$];
        logic [31:0] got_data, exp_data;
        logic [5:0]  got_cnt, exp_cnt;
        logic        got_err, exp_err;
        bit          in_win;

        tx_n = (tb_bits > 32) ? 32 : tb_bits;
        rx_n = (rb_bits > 32) ? 32 : rb_bits;

        for (int i = tx_n - 1; i >= 0; i--) begin
            int lo, hi;
            lo = td[i] ? C : 3 * C;
            hi = td[i] ? 3 * C : C;
            repeat (lo) eo.push_back(1'b1);
            repeat (hi) eo.push_back(1'b0);
        end
        if (tx_n > 0) begin
            repeat (C) eo.push_back(1'b1);
            repeat (2 * C) eo.push_back(1'b0);
        end
        txc = eo.size();

        if (rx_n > 0 && nresp > 0) begin
            repeat (txc + gap) sched.push_back(1'b0);
            for (int i = nresp - 1; i >= 0; i--) begin
                int lo, hi;
                lo = resp[i] ? C : 3 * C;
                hi = resp[i] ? 3 * C : C;
                repeat (lo) sched.push_back(1'b1);
                repeat (hi) sched.push_back(1'b0);
            end
            if (stop) begin
                repeat (C) sched.push_back(1'b1);
                sched.push_back(1'b0);
            end
        end
        limit = sched.size() + txc + 2 * TO + 50;

        done_c   = -1;
        done_cnt = 0;
        oe_bad   = 0;
        busy_bad = 0;
        got_data = '1;
        got_cnt  = '1;
        got_err  = 1'bx;

        @(negedge PCLK);
        tx_data = td;
        tx_bits = 6'(tb_bits);
        rx_bits = 6'(rb_bits);
        start   = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge PCLK);
            start = (c == mid);
            if (c == mid) begin
                tx_data = ~td;
                tx_bits = 6'd5;
            end
            ctrl_low = (c < sched.size()) ? sched[c] : 1'b0;
            if (line_oe !== ((c < txc) ? eo[c] : 1'b0)) oe_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c   = c;
                    got_data = rx_data;
                    got_cnt  = rx_count;
                    got_err  = rx_err;
                end
            end
            if (busy !== ((done_c < 0) ? 1'b1 : 1'b0)) busy_bad++;
            if (done_c >= 0 && c >= done_c + 3) break;
        end
        start    = 1'b0;
        ctrl_low = 1'b0;

        if (rx_n == 0) begin
            exp_data = '0;
            exp_cnt  = '0;
            exp_err  = 1'b0;
        end else begin
            exp_data = 32'((64'd1 << nresp) - 64'd1) & resp;
            exp_cnt  = 6'(nresp);
            exp_err  = !(nresp == rx_n && stop);
        end

        chk("done_pulses", done_cnt, 1);
        chk("line_oe_wave_errs", oe_bad, 0);
        chk("busy_errs", busy_bad, 0);
        chk("rx_data", got_data, exp_data);
        chk("rx_count", got_cnt, exp_cnt);
        chk("rx_err", got_err, exp_err);
        if (rx_n == 0) begin
            chk("done_cycle", done_c, txc);
        end else if (nresp == 0) begin
            in_win = (done_c >= txc + TO) && (done_c <= txc + TO + 2);
            if (!in_win) $display("timeout done at cycle %0d, window starts %0d", done_c, txc + TO);
            chk("timeout_done_window", in_win, 1'b1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge PCLK);
        chk("rst_line_oe", line_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_rx_err", rx_err, 0);
        PRESERN = 1'b1;
        repeat (2) @(negedge PCLK);

        // Poll with full response and stop bit.
        run_txn(32'h01, 8, 32, 32, 32'h80000001, 1'b1, 4, -1);
        // No response at all.
        run_txn(32'h01, 8, 32, 0, 32'h0, 1'b0, 4, -1);
        // Response stops after 10 bits.
        run_txn(32'h01, 8, 32, 10, 32'h2A5, 1'b0, 4, -1);
        // 32 bits but no stop bit.
        run_txn(32'h01, 8, 32, 32, 32'hDEADBEEF, 1'b0, 3, -1);
        // start pulsed mid-TX.
        run_txn(32'h01, 8, 32, 32, 32'h12345678, 1'b1, 5, 40);
        // Nothing to send or receive.
        run_txn(32'h0, 0, 0, 0, 32'h0, 1'b0, 1, -1);
        // Listen only.
        run_txn(32'h3, 0, 5, 5, 32'h15, 1'b1, 2, -1);
        // Saturation of both counts.
        run_txn(32'hC3A5_0F96, 40, 40, 32, 32'h5A5A_C3C3, 1'b1, 2, -1);
        // Transmit only.
        run_txn(32'h41, 7, 0, 0, 32'h0, 1'b0, 1, -1);

        // Asynchronous reset during the first TX_LOW.
        @(negedge PCLK);
        tx_data = 32'h0;
        tx_bits = 6'd8;
        rx_bits = 6'd8;
        start   = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        @(negedge PCLK);
        chk("oe_before_reset", line_oe, 1);
        #2 PRESERN = 1'b0;
        #1;
        chk("oe_async_reset", line_oe, 0);
        chk("busy_async_reset", busy, 0);
        chk("done_async_reset", done, 0);
        @(negedge PCLK);
        PRESERN = 1'b1;
        @(negedge PCLK);
        chk("busy_after_reset", busy, 0);
        chk("oe_after_reset", line_oe, 0);
        run_txn(32'h0000_00B1, 8, 16, 16, 32'h0000_9C3E, 1'b1, 3, -1);

        for (int t = 0; t < 20; t++) begin
            int          tbb, rbb, rxn, mode, nr, md;
            bit          st;
            logic [31:0] td, rs;
            tbb  = $urandom_range(0, 40);
            rbb  = $urandom_range(0, 40);
            rxn  = (rbb > 32) ? 32 : rbb;
            td   = $urandom;
            rs   = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin nr = rxn; st = 1'b1; end
                1: begin nr = 0;   st = 1'b0; end
                2: begin nr = (rxn > 0) ? $urandom_range(0, rxn - 1) : 0; st = 1'b0; end
                default: begin nr = rxn; st = 1'b0; end
            endcase
            md = (tbb > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : -1;
            run_txn(td, tbb, rbb, nr, rs, st, $urandom_range(1, 8), md);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
